// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN neuron configuration path.
// Sized for the default 12-neuron array with 8-bit weights and 4-bit thresholds.
package bnn_pkg;

    localparam int NUM_NEURONS = 12;
    localparam int W_BITS      = 8;
    localparam int T_BITS      = 4;
    localparam int IDX_BITS    = 4;

    typedef enum logic [2:0] {
        IDLE,
        W_LO,
        W_HI,
        THR,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/bnn_cfg_seq_if.sv
// Control, nibble-stream and register-file write signals of the config sequencer.
// master drives start/abort/nibbles; slave is the sequencer itself.
interface bnn_cfg_seq_if #(
    parameter int W_BITS   = bnn_pkg::W_BITS,
    parameter int T_BITS   = bnn_pkg::T_BITS,
    parameter int IDX_BITS = bnn_pkg::IDX_BITS
);

    logic                start;
    logic                abort;
    logic                nib_valid;
    logic [3:0]          nib_data;
    logic                nib_ready;
    logic                wr_en;
    logic [IDX_BITS-1:0] wr_addr;
    logic [W_BITS-1:0]   wr_weight;
    logic [T_BITS-1:0]   wr_thresh;
    logic                busy;
    logic                done;
    logic                cfg_valid;
    logic                err;

    modport master (
        output start, abort, nib_valid, nib_data,
        input  nib_ready, wr_en, wr_addr, wr_weight, wr_thresh,
        input  busy, done, cfg_valid, err
    );

    modport slave (
        input  start, abort, nib_valid, nib_data,
        output nib_ready, wr_en, wr_addr, wr_weight, wr_thresh,
        output busy, done, cfg_valid, err
    );

endinterface

// File: rtl/bnn_cfg_seq.sv
// Assembles weight/threshold nibbles per neuron and writes them to the
// neuron register file, one neuron every four cycles when the stream is dense.
module bnn_cfg_seq #(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int W_BITS      = bnn_pkg::W_BITS,
    parameter int T_BITS      = bnn_pkg::T_BITS
) (
    input  logic          clk,
    input  logic          reset,
    bnn_cfg_seq_if.slave  bus
);
    import bnn_pkg::*;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    logic [W_BITS-1:0]   weight_q, weight_d;
    logic                wr_en_q, wr_en_d;
    logic [IDX_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [W_BITS-1:0]   wr_weight_q, wr_weight_d;
    logic [T_BITS-1:0]   wr_thresh_q, wr_thresh_d;
    logic                done_q, done_d;
    logic                cfg_q, cfg_d;
    logic                err_q, err_d;
    logic                ready;
    logic                accept;

    assign ready  = (state_q == W_LO) || (state_q == W_HI) || (state_q == THR);
    assign accept = ready && bus.nib_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        weight_d    = weight_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_weight_d = wr_weight_q;
        wr_thresh_d = wr_thresh_q;
        done_d      = 1'b0;
        cfg_d       = cfg_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.nib_valid) err_d = 1'b1;
                if (bus.start && !bus.abort) begin
                    state_d = W_LO;
                    cnt_d   = '0;
                    cfg_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            W_LO: if (accept) begin
                weight_d[3:0] = bus.nib_data;
                state_d       = W_HI;
            end
            W_HI: if (accept) begin
                weight_d[7:4] = bus.nib_data;
                state_d       = THR;
            end
            // write port is loaded here so the strobe and data are registered
            THR: if (accept) begin
                state_d     = WRITE;
                wr_en_d     = 1'b1;
                wr_addr_d   = cnt_q;
                wr_weight_d = weight_q;
                wr_thresh_d = T_BITS'(bus.nib_data);
            end
            WRITE: begin
                if (cnt_q == IDX_BITS'(NUM_NEURONS - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = W_LO;
                end
            end
            DONE: begin
                cfg_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d     = IDLE;
            cnt_d       = '0;
            weight_d    = '0;
            wr_en_d     = 1'b0;
            wr_addr_d   = wr_addr_q;
            wr_weight_d = wr_weight_q;
            wr_thresh_d = wr_thresh_q;
            done_d      = 1'b0;
            cfg_d       = cfg_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            weight_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_weight_q <= '0;
            wr_thresh_q <= '0;
            done_q      <= 1'b0;
            cfg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            weight_q    <= weight_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_weight_q <= wr_weight_d;
            wr_thresh_q <= wr_thresh_d;
            done_q      <= done_d;
            cfg_q       <= cfg_d;
            err_q       <= err_d;
        end
    end

    assign bus.nib_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_weight = wr_weight_q;
    assign bus.wr_thresh = wr_thresh_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.cfg_valid = cfg_q;
    assign bus.err       = err_q;

endmodule
